// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync + per-bit run-length filter, then step/direction/illegal-move detection.
// Latency FILT_LEN+3 edges from input to step; no backpressure, step is a free-running one-cycle pulse.
module quad_decoder #(
  parameter int FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clr,
  output logic       ud,
  output logic       step,
  output logic       err,
  output logic [1:0] ab
);

  localparam logic [3:0] CNT_LAST  = 4'(FILT_LEN - 1);
  localparam logic [4:0] PRIME_LEN = 5'(FILT_LEN + 2);

  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0][3:0] cnt;
  logic [1:0]      ab_d;
  logic [4:0]      prime_cnt;
  logic            unprimed;
  logic            is_up;
  logic            is_dn;
  logic            is_ill;

  assign unprimed = (prime_cnt != PRIME_LEN);

  function automatic logic [1:0] up_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 2'b00;
      sync2     <= 2'b00;
      cnt       <= '0;
      ab        <= 2'b00;
      ab_d      <= 2'b00;
      prime_cnt <= 5'd0;
    end else begin
      sync1 <= {a_in, b_in};
      sync2 <= sync1;
      if (unprimed) begin
        // Track the inputs directly so priming never looks like a transition.
        prime_cnt <= prime_cnt + 5'd1;
        ab        <= sync2;
        ab_d      <= sync2;
        cnt       <= '0;
      end else begin
        ab_d <= ab;
        for (int i = 0; i < 2; i++) begin
          if (sync2[i] != ab[i]) begin
            if (cnt[i] == CNT_LAST) begin
              ab[i]  <= sync2[i];
              cnt[i] <= 4'd0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end else begin
            cnt[i] <= 4'd0;
          end
        end
      end
    end
  end

  always_comb begin
    is_up  = 1'b0;
    is_dn  = 1'b0;
    is_ill = 1'b0;
    if (!unprimed && (ab != ab_d)) begin
      if (ab == ~ab_d)               is_ill = 1'b1;
      else if (ab == up_next(ab_d))  is_up  = 1'b1;
      else                           is_dn  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step <= 1'b0;
      ud   <= 1'b1;
      err  <= 1'b0;
    end else begin
      step <= is_up | is_dn;
      if (is_up)      ud <= 1'b1;
      else if (is_dn) ud <= 1'b0;
      // A new illegal move wins over a clear in the same cycle.
      err <= is_ill | (err & ~clr);
    end
  end

endmodule
